// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // next-PC select; anything other than PC_SEQ is a redirect
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JR     = 2'b11
    } pc_src_e;

    // FETCH: request outstanding, HOLD: word parked under stall, DRAIN: killed request in flight
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HOLD  = 2'b01,
        ST_DRAIN = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/mux_32bit_4in.sv
// Generic 32-bit 4:1 multiplexer.
module mux_32bit_4in (
    input  logic [1:0]  sel,
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    output logic [31:0] y
);

    // select one of four inputs
    always_comb begin
        y = d0;
        case (sel)
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, memory request handshake, IF/ID register.
// Redirects that arrive while a request is outstanding are parked until the
// killed request completes, so imem_addr never changes mid-transaction.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

    fetch_state_e state, state_nxt;
    logic [31:0]  pc_q, pc4, hold_q, saved_q, mux_out, target;
    logic         redirect;
    if_id_t       ifid_q;

    assign pc4      = pc_q + 32'd4;
    assign redirect = (pc_src != PC_SEQ);
    assign target   = mux_out & ~32'h3;

    mux_32bit_4in u_next_pc (
        .sel (pc_src),
        .d0  (pc4),
        .d1  (branch_addr),
        .d2  (jump_addr),
        .d3  (jr_addr),
        .y   (mux_out)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nxt;
    end

    // FSM next state: redirect beats stall beats advance
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (imem_ack) state_nxt = (!redirect && stall) ? ST_HOLD : ST_FETCH;
                else          state_nxt = redirect ? ST_DRAIN : ST_FETCH;
            end
            ST_HOLD:  if (redirect || !stall) state_nxt = ST_FETCH;
            ST_DRAIN: if (imem_ack) state_nxt = ST_FETCH;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    // FSM outputs: no request while a word is parked or in reset
    always_comb begin
        imem_req = 1'b0;
        if (!rst && state != ST_HOLD) imem_req = 1'b1;
    end

    // PC, hold buffer, saved target and IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= PC_INIT;
            hold_q  <= '0;
            saved_q <= '0;
            ifid_q  <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            pc_q         <= target;
                            ifid_q.valid <= 1'b0;
                        end else if (stall) begin
                            hold_q <= imem_rdata;
                        end else begin
                            ifid_q <= '{pc4: pc4, instr: imem_rdata, valid: 1'b1};
                            pc_q   <= pc4;
                        end
                    end else if (redirect) begin
                        saved_q      <= target;
                        ifid_q.valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_q.valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc_q         <= target;
                        ifid_q.valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_q <= '{pc4: pc4, instr: hold_q, valid: 1'b1};
                        pc_q   <= pc4;
                    end
                end
                ST_DRAIN: begin
                    ifid_q.valid <= 1'b0;
                    if (redirect) saved_q <= target;
                    // a redirect landing with the ack is the newest target
                    if (imem_ack) pc_q <= redirect ? target : saved_q;
                end
                default: ifid_q.valid <= 1'b0;
            endcase
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q & ~32'h3;
    assign if_id_pc4   = ifid_q.pc4;
    assign if_id_instr = ifid_q.instr;
    assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an IF/ID scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_addr, jump_addr, jr_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] pc, if_id_pc4, if_id_instr;
    logic        if_id_valid;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc4 = '0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc_src      (pc_src),
        .branch_addr (branch_addr),
        .jump_addr   (jump_addr),
        .jr_addr     (jr_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .pc          (pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock; any newly loaded IF/ID entry must match the queue head
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (if_id_valid === 1'b1 && (!prev_valid || if_id_pc4 !== prev_pc4)) begin
            if (exp_q.size() == 0) begin
                chk("ifid_unexpected", if_id_pc4, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("ifid_pc4", if_id_pc4, e[63:32]);
                chk("ifid_instr", if_id_instr, e[31:0]);
            end
        end
        prev_valid = if_id_valid;
        prev_pc4   = if_id_pc4;
    endtask

    // drive one cycle of control and memory response, optionally expecting the word on IF/ID
    task automatic drive(input logic s, input logic [1:0] src, input logic a, input logic push);
        stall      = s;
        pc_src     = src;
        imem_ack   = a;
        imem_rdata = a ? word(imem_addr) : 32'hBAD0_BAD0;
        if (push) exp_q.push_back({imem_addr + 32'd4, word(imem_addr)});
        tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        chk({tag, "_pc4"}, if_id_pc4, 32'h0);
        chk({tag, "_instr"}, if_id_instr, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_src = 2'b00; imem_ack = 1'b0; imem_rdata = '0;
        branch_addr = '0; jump_addr = '0; jr_addr = '0;
        tick(); tick();
        chk_reset("reset");

        rst = 1'b0;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        // streaming fetch, ack every cycle
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", imem_addr, 32'(i * 4));
            drive(1'b0, 2'b00, 1'b1, 1'b1);
        end
        chk("seq_valid", {31'b0, if_id_valid}, 32'h1);

        // ack under stall parks the word in HOLD
        chk("hold_pc", pc, 32'h10);
        drive(1'b1, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("hold_req", {31'b0, imem_req}, 32'h0);
            chk("hold_ifid_pc4", if_id_pc4, 32'h10);
            drive(1'b1, 2'b00, 1'b0, 1'b0);
        end
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("hold_release_addr", imem_addr, 32'h14);
        chk("hold_release_req", {31'b0, imem_req}, 32'h1);

        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 1'b1, 1'b1);

        // branch while the fetch at 0x20 is unacked
        branch_addr = 32'h100;
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        chk("drain_addr", imem_addr, 32'h20);
        chk("drain_valid", {31'b0, if_id_valid}, 32'h0);
        chk("drain_req", {31'b0, imem_req}, 32'h1);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("drain_addr2", imem_addr, 32'h20);
        chk("drain_valid2", {31'b0, if_id_valid}, 32'h0);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("drain_done_addr", imem_addr, 32'h100);
        chk("drain_done_valid", {31'b0, if_id_valid}, 32'h0);
        drive(1'b0, 2'b00, 1'b1, 1'b1);

        // jump then jr during DRAIN: last target wins, low bits cleared
        jump_addr = 32'h300;
        drive(1'b0, 2'b10, 1'b0, 1'b0);
        jr_addr = 32'h203;
        drive(1'b0, 2'b11, 1'b0, 1'b0);
        chk("jr_drain_addr", imem_addr, 32'h104);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("jr_target", imem_addr, 32'h200);
        drive(1'b0, 2'b00, 1'b1, 1'b1);

        // redirect on the ack cycle, then wrap at the top of memory
        jump_addr = 32'hFFFF_FFFC;
        drive(1'b0, 2'b10, 1'b1, 1'b0);
        chk("ack_redirect_addr", imem_addr, 32'hFFFF_FFFC);
        chk("ack_redirect_valid", {31'b0, if_id_valid}, 32'h0);
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // redirect out of HOLD discards the parked word
        drive(1'b1, 2'b00, 1'b1, 1'b0);
        chk("hold2_req", {31'b0, imem_req}, 32'h0);
        branch_addr = 32'h41;
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        chk("hold_redirect_addr", imem_addr, 32'h40);
        chk("hold_redirect_valid", {31'b0, if_id_valid}, 32'h0);
        chk("hold_redirect_req", {31'b0, imem_req}, 32'h1);

        // waiting without ack: stalled and bubbling
        drive(1'b1, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("wait_addr", imem_addr, 32'h40);
        chk("wait_valid", {31'b0, if_id_valid}, 32'h0);

        // asynchronous reset in the middle of DRAIN
        branch_addr = 32'h80;
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        chk("pre_rst_addr", imem_addr, 32'h40);
        pc_src = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk_reset("rst_ack");
        rst = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("restart_req", {31'b0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        chk("restart_next", imem_addr, 32'h4);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard unit holds the PC and the IF/ID register.
REQ-005 pc_src  input  2  next-PC select: 00 PC+4, 01 branch_addr, 10 jump_addr, 11 jr_addr; any nonzero value is a redirect.
REQ-006 branch_addr, jump_addr, jr_addr  input  32 each  redirect targets from the decode and EX stages.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  32  fetch address; bits [1:0] are always 00.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-010 imem_ack  input  1  one-cycle completion of the outstanding request; latency 1..N cycles.
REQ-011 pc  output  32  address of the current or outstanding fetch.
REQ-012 if_id_pc4, if_id_instr  output  32 each  IF/ID register contents.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.

Function
REQ-014 FSM states: FETCH (request outstanding), HOLD (word received while stalled, no request), DRAIN (discarding a killed request).
REQ-015 imem_req=1 in FETCH and DRAIN and 0 in HOLD; imem_addr=pc, held stable until ack.
REQ-016 Redirect target = mux(pc_src) with bits [1:0] forced to 00; PC+4 wraps modulo 2^32.
REQ-017 Priority: redirect > stall > normal advance.
REQ-018 FETCH, ack, no redirect, no stall: IF/ID <= {pc+4, imem_rdata, 1}; pc <= pc+4; stay in FETCH.
REQ-019 FETCH, ack, stall, no redirect: IF/ID held; imem_rdata -> hold buffer; pc held; go to HOLD.
REQ-020 FETCH, ack, redirect: data discarded; if_id_valid <= 0; pc <= target; stay in FETCH.
REQ-021 FETCH, no ack, redirect: target -> saved register; if_id_valid <= 0; go to DRAIN; pc and imem_addr unchanged.
REQ-022 FETCH, no ack, no redirect: if stall, IF/ID held; otherwise if_id_valid <= 0 (bubble).
REQ-023 HOLD, redirect: buffered word discarded; if_id_valid <= 0; pc <= target; go to FETCH.
REQ-024 HOLD, no stall: IF/ID <= {pc+4, buffered word, 1}; pc <= pc+4; go to FETCH next cycle.
REQ-025 HOLD, stall: no change.
REQ-026 DRAIN: if_id_valid=0 in every cycle; a new redirect overwrites the saved target; on ack, data discarded, pc <= saved target, go to FETCH.
REQ-027 Pipeline latency: an instruction acked in cycle N with no stall appears on IF/ID in cycle N+1.
REQ-028 pc_src and targets are sampled only in the cycle they are presented.
REQ-029 The IF/ID payload is unchanged whenever if_id_valid is held by stall.

Reset
REQ-030 While rst=1: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_pc4=0, if_id_instr=0, imem_req=0, hold and saved-target registers cleared.
REQ-031 The first edge after rst deasserts has imem_req=1 with imem_addr=RESET_PC.
REQ-032 An ack coinciding with reset assertion is ignored.

Structure
REQ-033 A shared package holds the pc_src encodings (PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR), the FSM state encodings, and the RESET_PC default.
REQ-034 Next-PC selection instantiates the existing mux_32bit_4in; no other sub-module.

Verification
REQ-035 Reset, ack every cycle, no stall -> imem_addr 0,4,8,...; IF/ID pc4 4,8,... with valid=1 from cycle 2.
REQ-036 Ack at pc=0x10 with stall=1 for 3 cycles -> HOLD, imem_req=0, IF/ID unchanged; after stall drops, IF/ID={0x14, word, 1}, next imem_addr=0x14.
REQ-037 pc_src=01, branch_addr=0x100, while the fetch at 0x20 is unacked -> DRAIN, imem_addr stays 0x20, if_id_valid=0; after ack, imem_addr=0x100, killed word never appears on IF/ID.
REQ-038 pc_src=10 then 11 (jr_addr=0x203) during DRAIN -> final fetch at 0x200.
REQ-039 pc=0xFFFF_FFFC, acked -> if_id_pc4=0, next imem_addr=0.
REQ-040 rst asserted mid-DRAIN -> outputs match REQ-030 asynchronously; fetch restarts at RESET_PC.
